// File: rtl/conv_pkg.sv
// Shared definitions for the convolution filter scheduler.
// Holds the FSM state encoding, the default geometry localparams and the
// helpers used to size the ports when the geometry is overridden.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, STORE, DONE} state_t;

  // Default layer geometry
  localparam int P_DW = 8;
  localparam int P_D  = 1;
  localparam int P_H  = 8;
  localparam int P_W  = 8;
  localparam int P_F  = 3;

  localparam int OUT_DIM = P_H - P_F + 1;
  localparam int FSZ     = P_D * P_F * P_F * P_DW;
  localparam int OSZ     = OUT_DIM * (P_W - P_F + 1) * P_DW;

  // Bits in one filter
  function automatic int f_fsz(input int d, input int f, input int dw);
    return d * f * f * dw;
  endfunction

  // Bits in one output feature map
  function automatic int f_osz(input int h, input int w, input int f, input int dw);
    return (h - f + 1) * (w - f + 1) * dw;
  endfunction

  // Number of engine passes needed to cover all filters
  function automatic int f_groups(input int k, input int n_eng);
    return k / n_eng;
  endfunction

endpackage

// File: rtl/conv_sched_done_tracker.sv
// Per-engine sticky completion flags.
// Ports:
//   i_clk, i_reset  clock, async active-high reset
//   i_clr           synchronous clear of all flags
//   i_en            capture window; i_done is ignored while low
//   i_done          per-engine completion (level or pulse)
//   o_all_done      every engine has finished, including this cycle's i_done
module conv_sched_done_tracker
  import conv_pkg::*;
#(
  parameter int N_ENG = 2
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [N_ENG-1:0] i_done,
  output logic             o_all_done
);

  logic [N_ENG-1:0] r_flags;
  logic [N_ENG-1:0] w_done_q;

  assign w_done_q = i_en ? i_done : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   r_flags <= '0;
    else if (i_clr) r_flags <= '0;
    else           r_flags <= r_flags | w_done_q;
  end

  // Include the current cycle so the last finisher does not cost an extra cycle
  assign o_all_done = &(r_flags | w_done_q);

endmodule

// File: rtl/conv_filter_scheduler.sv
// Time-shares N_ENG single-filter engines across K filters. Each group of
// N_ENG filters is loaded, run until every engine reports done, and its maps
// are stored into the assembled output vector.
// Ports:
//   i_clk, i_reset   clock, async active-high reset
//   i_start          begin a layer (accepted in IDLE only)
//   i_filters        all K filters, filter k at bit offset k*FSZ
//   i_eng_done       per-engine completion
//   i_eng_out        engine maps, engine e at bit offset e*OSZ
//   o_eng_reset      engine reset, low only while running
//   o_eng_filters    filter slices of the current group
//   o_busy, o_done   activity level and one-cycle completion pulse
//   o_error          sticky run timeout flag
//   o_outputConv     assembled maps, filter k at bit offset k*OSZ
// Optional feature: define CONV_SCHED_TIMEOUT_EN to abort a group whose RUN
// phase lasts TIMEOUT cycles without all engines finishing.
module conv_filter_scheduler
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = P_DW,
  parameter int D          = P_D,
  parameter int H          = P_H,
  parameter int W          = P_W,
  parameter int F          = P_F,
  parameter int K          = 6,
  parameter int N_ENG      = 2,
  parameter int TIMEOUT    = 1024,
  localparam int LFSZ      = f_fsz(D, F, DATA_WIDTH),
  localparam int LOSZ      = f_osz(H, W, F, DATA_WIDTH)
)(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [0:K*LFSZ-1]     i_filters,
  input  logic [N_ENG-1:0]      i_eng_done,
  input  logic [0:N_ENG*LOSZ-1] i_eng_out,
  output logic                  o_eng_reset,
  output logic [0:N_ENG*LFSZ-1] o_eng_filters,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [0:K*LOSZ-1]     o_outputConv
);

  localparam int NG  = f_groups(K, N_ENG);
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int GFW = N_ENG * LFSZ;
  localparam int GOW = N_ENG * LOSZ;
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

  if ((K % N_ENG) != 0) begin : g_k_check
    $error("K must be a multiple of N_ENG");
  end

  state_t           r_state, w_state_n;
  logic [GW-1:0]    r_g;
  logic [0:GFW-1]   r_eng_filters;
  logic [0:K*LOSZ-1] r_out;
  logic             r_err;
  logic             w_run, w_all_done, w_timeout;

  assign w_run = (r_state == RUN);

  conv_sched_done_tracker #(.N_ENG(N_ENG)) u_trk (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (r_state == LOAD),
    .i_en       (w_run),
    .i_done     (i_eng_done),
    .o_all_done (w_all_done)
  );

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                r_cnt <= '0;
    else if (r_state == LOAD)   r_cnt <= '0;
    else if (w_run)             r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt counts completed RUN cycles, so this is the TIMEOUT-th one
  assign w_timeout = w_run && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:  if (i_start) w_state_n = LOAD;
      LOAD:  w_state_n = RUN;
      RUN:   if (w_all_done)     w_state_n = STORE;
             else if (w_timeout) w_state_n = DONE;
      STORE: w_state_n = (r_g == G_LAST) ? DONE : LOAD;
      DONE:  w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Filter slices are registered on the edge entering LOAD so they are
  // already stable during LOAD and stay put through STORE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_g           <= '0;
      r_eng_filters <= '0;
      r_out         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_n;
      case (r_state)
        IDLE: if (i_start) begin
          r_g           <= '0;
          r_out         <= '0;
          r_err         <= 1'b0;
          r_eng_filters <= i_filters[0 +: GFW];
        end
        RUN: if (w_timeout && !w_all_done) r_err <= 1'b1;
        STORE: begin
          r_out[int'(r_g)*GOW +: GOW] <= i_eng_out;
          if (r_g != G_LAST) begin
            r_g           <= r_g + 1'b1;
            r_eng_filters <= i_filters[(int'(r_g)+1)*GFW +: GFW];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_eng_reset   = !w_run;
  assign o_eng_filters = r_eng_filters;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);
  assign o_error       = r_err;
  assign o_outputConv  = r_out;

endmodule

// File: doc/conv_filter_scheduler.md
# conv_filter_scheduler

Sequencer that time-shares a bank of N_ENG single-filter convolution engines across all K filters of a layer. It hands each engine group its filter slices, holds the engines in reset between passes, collects per-engine completion, and assembles the K feature maps into one output vector. The handshake replaces fixed cycle-count timing, so engine latency can change without retuning the controller. It sits between the layer-level control and the engine array.

## Interface
- DATA_WIDTH, 8, element width
- D, 1, image/filter depth
- H, 8, image height
- W, 8, image width
- F, 3, filter size
- K, 6, number of filters; must be a multiple of N_ENG (elaboration-time check)
- N_ENG, 2, number of engines
- TIMEOUT, 1024, RUN-state cycle limit; used only with CONV_SCHED_TIMEOUT_EN
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a layer; sampled in IDLE only
- filters  in  K*D*F*F*DATA_WIDTH  all filters, big-endian [0:…]; filter k at offset k*FSZ, FSZ=D*F*F*DATA_WIDTH
- eng_done  in  N_ENG  per-engine completion level/pulse
- eng_out  in  N_ENG*OSZ  engine maps; engine e at offset e*OSZ, OSZ=(H-F+1)*(W-F+1)*DATA_WIDTH
- eng_reset  out  1  engine reset
- eng_filters  out  N_ENG*FSZ  filter slices for the current group
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag
- outputConv  out  K*OSZ  assembled maps; filter k at offset k*OSZ

## Operation
- G = K/N_ENG groups. Group g drives filters[g*N_ENG*FSZ +: N_ENG*FSZ] onto eng_filters, registered.
- FSM:
  - IDLE: start=1 → LOAD. Clear outputConv, error and group index.
  - LOAD: one cycle, eng_reset=1, eng_filters updated, done tracker cleared → RUN.
  - RUN: eng_reset=0. Per-engine sticky flags capture eng_done. All flags set → STORE.
  - STORE: one cycle. Write eng_out into outputConv[(g*N_ENG)*OSZ +: N_ENG*OSZ]. If g==G-1 → DONE, else g+1 → LOAD.
  - DONE: done=1 for one cycle → IDLE.
- Outside RUN, eng_done is ignored, including stale assertions during LOAD.
- start is ignored in every state except IDLE.
- Engines may finish on different cycles; sticky flags hold early finishers.
- outputConv holds its value after DONE until the next accepted start or reset.
- Reset values: FSM in IDLE, eng_reset=1 (engines held in reset while idle), eng_filters=0, outputConv=0, busy=0, done=0, error=0, group index=0, tracker flags=0.
- Reset mid-operation: immediate return to IDLE with reset values. Partial results are discarded.

## Timing
- Edge 0 samples start in IDLE. LOAD is cycle 1 and RUN begins cycle 2.
- Each group costs 1 (LOAD) + R_g (RUN cycles, including the cycle all flags become set) + 1 (STORE).
- done is high in cycle 1 + Σ(R_g+2). busy is high from cycle 1 through the DONE cycle.
- eng_filters is stable from LOAD through STORE of its group.
- outputConv slice is visible the cycle after STORE.

## Configuration
- CONV_SCHED_TIMEOUT_EN defined:
  - A RUN cycle counter resets on entry to LOAD.
  - If the counter reaches TIMEOUT with flags incomplete, the FSM sets error=1 and goes directly to DONE without storing the current group.
  - Slots of the current and later groups stay 0; earlier groups are kept.
  - error stays set until the next accepted start or reset.
- Not defined: no counter, error tied 0, and RUN waits indefinitely.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, STORE, DONE)
  - localparams FSZ, OSZ and OUT_DIM=H-F+1
  - the group-count function
- One sub-module, conv_sched_done_tracker: N_ENG sticky flags with synchronous clear and all_done output.

## Test plan
- K=6, N_ENG=2, engines assert eng_done in the 10th RUN cycle → three groups of 12 cycles; done in cycle 37; outputConv slots 0..5 equal the engine data presented at STORE cycles 12, 24, 36.
- filters bytes = filter index (0..5) → eng_filters holds {0,1} in group 0, {2,3} in group 1, {4,5} in group 2.
- Staggered completion: engine 0 done in RUN cycle 3 only (pulse), engine 1 in cycle 8 → STORE in the cycle after RUN cycle 8; group stored correctly.
- eng_done held high during LOAD, engines otherwise silent → FSM stays in RUN; no early STORE.
- reset asserted in RUN of group 1 → next cycle: IDLE, outputConv=0, eng_reset=1. start pulses during busy have no effect.
- With CONV_SCHED_TIMEOUT_EN and TIMEOUT=20, engine 1 never done in group 1 → error=1, done pulses, slots 0..1 valid, slots 2..5 = 0. Next start clears error.
